// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit timing logic for the Timing Module.
// Divides the clock into time quanta, sequences SYNC/TSEG1/TSEG2, applies
// hard synchronisation and SJW-bounded resynchronisation, and produces the
// sample point and transmit point strobes for the bit stream processor.
//
// Ports:
//   clock, reset_n       system clock, asynchronous active-low reset
//   brp                  prescaler, tq = brp+1 clocks
//   tseg1 / tseg2        segment lengths minus one, in tq
//   sjw                  resync jump width minus one, in tq
//   falling_edge         one-clock recessive-to-dominant edge pulse
//   rx_in                synchronised bus level (1 = recessive)
//   hard_sync_en         bus idle / SOF expected, edges hard-sync
//   tq_tick              strobe in the last clock of every tq
//   sample_point         strobe in the cycle after rx_in is sampled
//   sampled_bit          last sampled bus value
//   tx_point             strobe in the cycle after each SYNC entry
//   seg_state            0 = SYNC, 1 = TSEG1, 2 = TSEG2
module can_bit_timing #(
  parameter int unsigned BRP_W   = 6,
  parameter int unsigned TSEG1_W = 4,
  parameter int unsigned TSEG2_W = 3,
  parameter int unsigned SJW_W   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]   sjw,
  input  logic               falling_edge,
  input  logic               rx_in,
  input  logic               hard_sync_en,
  output logic               tq_tick,
  output logic               sample_point,
  output logic               sampled_bit,
  output logic               tx_point,
  output logic [1:0]         seg_state
);

  localparam int unsigned SEG_W = (TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W;
  // Room for tseg1+1 plus the maximum lengthening without overflow.
  localparam int unsigned IDX_W = ((SEG_W > SJW_W) ? SEG_W : SJW_W) + 2;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_TSEG1 = 2'd1;
  localparam logic [1:0] ST_TSEG2 = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BRP_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   len1_q, len1_d;
  logic [IDX_W-1:0]   len2_q, len2_d;
  logic               edge_lock_q, edge_lock_d;
  logic               sync_first_q, sync_first_d;
  logic               init_q, init_d;
  logic [BRP_W-1:0]   brp_q, brp_d;
  logic [TSEG1_W-1:0] tseg1_q, tseg1_d;
  logic [TSEG2_W-1:0] tseg2_q, tseg2_d;
  logic [SJW_W-1:0]   sjw_q, sjw_d;
  logic               sampled_bit_q, sampled_bit_d;
  logic               sample_point_q, sample_point_d;
  logic               tx_point_q, tx_point_d;

  logic [BRP_W-1:0]   brp_e;
  logic [TSEG1_W-1:0] tseg1_e;
  logic [TSEG2_W-1:0] tseg2_e;
  logic [SJW_W-1:0]   sjw_e;
  logic [IDX_W-1:0]   len1_nom, len2_nom, sjw_full, sjw_eff;
  logic [IDX_W-1:0]   len1_w, len2_w, late_e, late_adj, early_r;
  logic               tick_c, goto_sync;

  // Effective configuration: live inputs in the first SYNC cycle (that is
  // the latch cycle), latched copy for the rest of the bit.
  always_comb begin
    brp_e    = sync_first_q ? brp   : brp_q;
    tseg1_e  = sync_first_q ? tseg1 : tseg1_q;
    tseg2_e  = sync_first_q ? tseg2 : tseg2_q;
    sjw_e    = sync_first_q ? sjw   : sjw_q;
    len1_nom = IDX_W'(tseg1_e) + IDX_W'(1);
    len2_nom = IDX_W'(tseg2_e) + IDX_W'(1);
    sjw_full = IDX_W'(sjw_e) + IDX_W'(1);
    sjw_eff  = (sjw_full < len2_nom) ? sjw_full : len2_nom;
    // >= guards against a prescaler left above a newly latched smaller brp.
    tick_c   = (presc_q >= brp_e);
  end

  // Next-state: resync edge handling first, then the tq-driven advance.
  always_comb begin
    state_d        = state_q;
    presc_d        = tick_c ? '0 : presc_q + BRP_W'(1);
    idx_d          = idx_q;
    len1_d         = len1_q;
    len2_d         = len2_q;
    edge_lock_d    = edge_lock_q;
    sync_first_d   = 1'b0;
    init_d         = 1'b0;
    brp_d          = brp_q;
    tseg1_d        = tseg1_q;
    tseg2_d        = tseg2_q;
    sjw_d          = sjw_q;
    sampled_bit_d  = sampled_bit_q;
    sample_point_d = 1'b0;
    tx_point_d     = 1'b0;
    len1_w         = len1_q;
    len2_w         = len2_q;
    late_e         = '0;
    late_adj       = '0;
    early_r        = '0;
    goto_sync      = 1'b0;

    if (sync_first_q) begin
      brp_d   = brp;
      tseg1_d = tseg1;
      tseg2_d = tseg2;
      sjw_d   = sjw;
      len1_d  = len1_nom;
      len2_d  = len2_nom;
    end

    if (init_q) begin
      // First cycle out of reset acts as the SYNC entry decision.
      presc_d      = '0;
      tx_point_d   = 1'b1;
      sync_first_d = 1'b1;
    end else begin
      if (falling_edge && hard_sync_en) begin
        goto_sync = 1'b1;
      end else if (falling_edge && !edge_lock_q) begin
        edge_lock_d = 1'b1;
        if (state_q == ST_TSEG1) begin
          late_e   = idx_q + IDX_W'(1);
          late_adj = (late_e < sjw_eff) ? late_e : sjw_eff;
          len1_w   = len1_q + late_adj;
          len1_d   = len1_w;
        end else if (state_q == ST_TSEG2) begin
          early_r = len2_q - idx_q;
          if (early_r <= sjw_eff) begin
            goto_sync = 1'b1;
          end else begin
            len2_w = len2_q - sjw_eff;
            len2_d = len2_w;
          end
        end
      end

      if (goto_sync) begin
        // The edge cycle counts as the first clock of the new SYNC tq.
        state_d      = ST_SYNC;
        presc_d      = (brp_e == '0) ? '0 : BRP_W'(1);
        idx_d        = '0;
        tx_point_d   = 1'b1;
        sync_first_d = 1'b1;
        edge_lock_d  = 1'b1;
      end else if (tick_c) begin
        case (state_q)
          ST_SYNC: begin
            state_d = ST_TSEG1;
            idx_d   = '0;
          end
          ST_TSEG1: begin
            if (idx_q == len1_w - IDX_W'(1)) begin
              state_d        = ST_TSEG2;
              idx_d          = '0;
              sampled_bit_d  = rx_in;
              sample_point_d = 1'b1;
              edge_lock_d    = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          ST_TSEG2: begin
            if (idx_q == len2_w - IDX_W'(1)) begin
              state_d      = ST_SYNC;
              idx_d        = '0;
              tx_point_d   = 1'b1;
              sync_first_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          default: begin
            state_d = ST_SYNC;
            idx_d   = '0;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_SYNC;
      presc_q        <= '0;
      idx_q          <= '0;
      len1_q         <= '0;
      len2_q         <= '0;
      edge_lock_q    <= 1'b0;
      sync_first_q   <= 1'b1;
      init_q         <= 1'b1;
      brp_q          <= '0;
      tseg1_q        <= '0;
      tseg2_q        <= '0;
      sjw_q          <= '0;
      sampled_bit_q  <= 1'b1;
      sample_point_q <= 1'b0;
      tx_point_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      len1_q         <= len1_d;
      len2_q         <= len2_d;
      edge_lock_q    <= edge_lock_d;
      sync_first_q   <= sync_first_d;
      init_q         <= init_d;
      brp_q          <= brp_d;
      tseg1_q        <= tseg1_d;
      tseg2_q        <= tseg2_d;
      sjw_q          <= sjw_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_point_q <= sample_point_d;
      tx_point_q     <= tx_point_d;
    end
  end

  // tq_tick is a decode of the live prescaler so it marks the last clock
  // of the tq itself; it is held low through reset and the init cycle.
  assign tq_tick      = tick_c & ~init_q;
  assign sample_point = sample_point_q;
  assign sampled_bit  = sampled_bit_q;
  assign tx_point     = tx_point_q;
  assign seg_state    = state_q;

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- CAN bit timing logic in the Timing Module.
- Sits directly downstream of the edge detector and consumes its `falling_edge` pulse (recessive-to-dominant).
- Divides the clock into time quanta (tq) and sequences each bit through SYNC, TSEG1 and TSEG2.
- Performs hard synchronisation and SJW-bounded resynchronisation, and emits the sample point, sampled bit and transmit point for the bit stream processor.

Parameters:
- BRP_W, 6, width of the baud-rate prescaler field.
- TSEG1_W, 4, width of the tseg1 field.
- TSEG2_W, 3, width of the tseg2 field.
- SJW_W, 2, width of the sjw field.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- brp  input  BRP_W  prescaler; tq = brp+1 clocks.
- tseg1  input  TSEG1_W  TSEG1 length = tseg1+1 tq (PROP+PHASE1).
- tseg2  input  TSEG2_W  TSEG2 length = tseg2+1 tq (PHASE2).
- sjw  input  SJW_W  resync jump width = sjw+1 tq.
- falling_edge  input  1  one-clock pulse from edge detector.
- rx_in  input  1  synchronised bus level, 1 = recessive.
- hard_sync_en  input  1  from controller: bus idle / SOF expected.
- tq_tick  output  1  one-clock pulse at end of each tq.
- sample_point  output  1  one-clock pulse when rx_in is sampled.
- sampled_bit  output  1  last sampled bus value.
- tx_point  output  1  one-clock pulse on every SYNC entry.
- seg_state  output  2  0 = SYNC, 1 = TSEG1, 2 = TSEG2.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset_n asynchronous, active-low.
  - Reset state: seg_state = SYNC, prescaler = 0, tq index = 0, edge_lock = 0.
  - Reset outputs: sampled_bit = 1, tq_tick = 0, sample_point = 0, tx_point = 0.
- Config latching:
  - brp/tseg1/tseg2/sjw are latched on every SYNC entry, including the first cycle after reset.
  - Mid-bit changes have no effect until the next SYNC entry.
- Prescaler:
  - Counts 0..brp_latched; tq_tick is high in the cycle the count equals brp_latched, then the count wraps to 0.
  - brp = 0 gives tq_tick every clock.
- Segment sequencing (advances only on tq_tick):
  - SYNC lasts 1 tq, then goes to TSEG1 with index 0.
  - TSEG1 ends when index = len1-1, then goes to TSEG2.
  - TSEG2 ends when index = len2-1, then goes to SYNC.
  - len1 = tseg1+1 plus any lengthening; len2 = tseg2+1 minus any shortening.
- Outputs:
  - On the tick that ends TSEG1: sampled_bit <= rx_in, sample_point pulses in the following cycle, and edge_lock clears.
  - tx_point pulses in the cycle following each SYNC entry.
  - Nominal bit time is (1 + tseg1+1 + tseg2+1)·(brp+1) clocks.
- Effective SJW: sjw_eff = min(sjw+1, tseg2+1).
- Edge handling (a falling_edge is evaluated against the state and index of the cycle in which it is high):
  - Priority 1, hard sync: hard_sync_en = 1 → prescaler restarts at 0, state forced to SYNC, tx_point pulses, edge_lock sets. Applies in any state and ignores edge_lock.
  - Else, edge_lock = 1 → edge ignored.
  - Edge in SYNC: phase error 0; no change; edge_lock sets.
  - Edge in TSEG1 at index k: late edge, e = k+1. TSEG1 is lengthened by min(e, sjw_eff); edge_lock sets.
  - Edge in TSEG2 at index k: early edge, remaining r = len2-k.
    - If r <= sjw_eff: TSEG2 is terminated, the prescaler restarts, state goes to SYNC and tx_point pulses.
    - Else: TSEG2 is shortened by sjw_eff.
    - edge_lock sets in both cases.
- Simultaneous edge and tick:
  - An edge takes priority over the tick advance in the same cycle.
  - An edge on the tick that would end TSEG1 lengthens TSEG1, deferring the sample.
- Reset asserted mid-bit: immediate return to the reset state; all pulses are suppressed.

Test Plan (all with brp=1, tseg1=5, tseg2=2, sjw=1, giving 2 clocks/tq, 10 tq = 20 clocks per bit):
- Free-run after reset, rx_in = 0, no edges:
  - tx_point every 20 clocks; sample_point 14 clocks after each tx_point.
  - sampled_bit = 1 before the first sample, 0 after.
- hard_sync_en = 1 with a falling_edge in mid-TSEG2:
  - Next tx_point in the cycle after the edge.
  - sample_point 14 clocks after the edge; 20-clock periodicity resumes from there.
- Late edges in TSEG1:
  - Edge at TSEG1 index 0: sample_point 16 clocks after tx_point; next tx_point 22 clocks after.
  - Edge at index 3: lengthening clamped to 2 tq, so sample_point at 18 clocks and bit at 24 clocks.
- Early edges in TSEG2:
  - Edge at TSEG2 index 2 (r = 1): immediate SYNC; tx_point in the next cycle.
  - With sjw=0 and an edge at index 0 (r = 3): TSEG2 shrinks to 2 tq, so the bit is 18 clocks.
- Second falling_edge later in the same bit (hard_sync_en = 0): ignored, timing identical to the single-edge case. After the sample point, a new edge is accepted again.
- Mid-bit disturbances:
  - reset_n pulled low in TSEG1 for 3 clocks: all outputs at reset values, and the first tx_point occurs 2 clocks after release.
  - tseg1 changed to 7 mid-bit: the current bit is unchanged and the next bit is 24 clocks.
